tb_ctrl: RTL and testbench
==========================

Name: tb_ctrl

Overview:
- Sequencing controller for the 4-state (K=3) Viterbi traceback path memory.
- Gates survivor-decision writes from the ACS array into the memory over TB_DEPTH gap-free cycles, then switches the memory to read mode.
- Walks the trellis backwards from the best-metric state and emits one decoded bit per traceback step.
- Sits between the ACS/compare stage and the decoded-bit sink; owns the memory's write-enable.

Parameters:
- TB_DEPTH, 8, traceback depth; must equal the path-memory shift-register depth.
- CNT_W, 4, width of the internal write/trace counter; must satisfy 2^CNT_W > TB_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ACS decision vector valid this cycle.
- in_ready  out  1  controller accepts decisions (write phase).
- best_state  in  2  index of minimum path-metric state, sampled with the last write of a frame.
- tbpm_we  out  1  path-memory write enable: 1 = shift in decisions, 0 = read/shift out.
- sel_i  in  4  path-memory MSB outputs; bit s = survivor decision of state s.
- out_bit  out  1  decoded bit.
- out_valid  out  1  out_bit valid this cycle.
- frame_done  out  1  one-cycle pulse with the last decoded bit of a frame.
- frame_err  out  1  one-cycle pulse when a partial write frame is aborted.

Behaviour:
- Reset values: state WRITE, cnt 0, trace state 2'b00, in_ready 1, tbpm_we 0, out_bit 0, out_valid 0, frame_done 0, frame_err 0.
- Path memory shifts on every cycle with we=0. A write frame is therefore TB_DEPTH consecutive accepted cycles with no gaps.
- WRITE state:
  - in_ready = 1 and tbpm_we = in_valid, combinational.
  - Each in_valid cycle increments cnt.
  - On the cycle with in_valid and cnt == TB_DEPTH-1: latch best_state into trace state tstate, clear cnt, go to TRACE.
- Gap in WRITE: in_valid = 0 with cnt in 1..TB_DEPTH-1 → pulse frame_err, clear cnt, stay in WRITE. Memory contents are treated as junk until a full frame is rewritten. in_valid = 0 with cnt = 0 is idle, with no error.
- TRACE state (TB_DEPTH cycles):
  - in_ready = 0 and tbpm_we = 0.
  - Each cycle: d = sel_i[tstate]; out_bit = tstate[1]; out_valid = 1; tstate <= {tstate[0], d}; cnt++.
  - Outputs are registered, one cycle after the sel_i sample.
  - On step TB_DEPTH-1: frame_done pulses with that bit; return to WRITE with cnt 0.
- Bit order without the optional feature is newest-first.
- Latency: first decoded bit appears 2 cycles after the last accepted write.
- in_valid during TRACE is ignored (in_ready = 0). Upstream must hold it.
- Reset mid-frame or mid-trace aborts immediately to the reset values. No partial output after reset release.
- Counter compare is exact (== TB_DEPTH-1), so the counter never wraps.

Optional Feature:
- Macro TB_REVERSE_EN.
- Defined:
  - Traced bits go into a TB_DEPTH-bit reverse buffer instead of out_valid.
  - After TRACE, an extra EMIT state outputs the bits oldest-first, one per cycle, for TB_DEPTH cycles.
  - frame_done pulses on the last EMIT bit. in_ready stays 0 through EMIT.
  - Frame period is 3·TB_DEPTH cycles.
- Undefined: no EMIT state and no buffer; bits are emitted newest-first during TRACE.

Decomposition:
- Package viterbi_pkg holds:
  - TB_DEPTH default and state width 2.
  - FSM enum {WRITE, TRACE, EMIT}.
  - The predecessor function prev_state(s, d) = {s[0], d}.
- One sub-module, tb_rev_buf: TB_DEPTH-deep LIFO with push/pop/empty. Instantiated only under TB_REVERSE_EN.

Test Plan:
- Basic trace:
  - 8 gap-free writes, best_state = 2'b11, sel_i = 4'b0000 throughout trace.
  - Expect out_bit 1,1,0,0,0,0,0,0.
  - frame_done on the 8th bit; tbpm_we high exactly 8 cycles.
- Opposite decisions:
  - best_state = 2'b00, sel_i = 4'b1111.
  - Expect out_bit 0,0,1,1,1,1,1,1; in_ready low for the 8 trace cycles.
- Gap handling:
  - in_valid drops after 5 writes → frame_err pulse, cnt 0.
  - Then 8 writes → normal trace, no second frame_err.
- Reset mid-TRACE (after 3 bits):
  - out_valid = 0 and in_ready = 1 immediately.
  - Next full frame decodes correctly.
- Back-to-back:
  - in_valid held high across 3 frames; writes accepted only in WRITE.
  - 24 bits out, 3 frame_done pulses, no frame_err.
- TB_REVERSE_EN:
  - The basic-trace stimulus yields 0,0,0,0,0,0,1,1 in EMIT.
  - frame_done on the final bit.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the K=3 Viterbi traceback controller.
// The optional reverse (oldest-first) output is enabled by defining TB_REVERSE_EN.
package viterbi_pkg;

  localparam int TB_DEPTH_DEF = 8;
  localparam int ST_W         = 2;

  typedef enum logic [1:0] {
    WRITE = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } tb_state_e;

  // Predecessor of state s given survivor decision d (shift-register trellis).
  function automatic logic [ST_W-1:0] prev_state(input logic [ST_W-1:0] s, input logic d);
    return {s[0], d};
  endfunction

endpackage

// File: rtl/tb_rev_buf.sv
// LIFO used to turn newest-first traceback bits into oldest-first output.
// Only instantiated when TB_REVERSE_EN is defined.
module tb_rev_buf #(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(DEPTH + 1);

  logic          r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_top_idx;

  assign w_full    = (r_ptr == PW'(DEPTH));
  assign empty     = (r_ptr == '0);
  assign w_do_push = push && !w_full;
  assign w_do_pop  = pop && !empty;
  assign w_wr_idx  = AW'(r_ptr);
  assign w_top_idx = AW'(r_ptr - 1'b1);
  assign dout      = r_mem[w_top_idx];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_do_push) begin
      r_ptr <= r_ptr + 1'b1;
    end else if (w_do_pop) begin
      r_ptr <= r_ptr - 1'b1;
    end
  end

endmodule

// File: rtl/tb_ctrl.sv
// Traceback sequencer for the 4-state path memory: gap-free write frame, then trace.
// Define TB_REVERSE_EN to add an EMIT phase that outputs bits oldest-first.
import viterbi_pkg::*;

module tb_ctrl #(
  parameter int TB_DEPTH = TB_DEPTH_DEF,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ST_W-1:0] best_state,
  output logic            tbpm_we,
  input  logic [3:0]      sel_i,
  output logic            out_bit,
  output logic            out_valid,
  output logic            frame_done,
  output logic            frame_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TB_DEPTH - 1);

  tb_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ST_W-1:0]  r_tstate;
  logic             r_out_bit;
  logic             r_out_valid;
  logic             r_frame_done;
  logic             r_frame_err;
  logic             w_last;
  logic             w_d;

  assign w_last     = (r_cnt == LAST);
  assign w_d        = sel_i[r_tstate];
  assign in_ready   = (r_state == WRITE);
  assign tbpm_we    = (r_state == WRITE) && in_valid;
  assign out_bit    = r_out_bit;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;

`ifdef TB_REVERSE_EN
  logic w_buf_bit;
  logic w_buf_empty;

  tb_rev_buf #(.DEPTH(TB_DEPTH)) u_rev_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_state == TRACE),
    .pop   (r_state == EMIT),
    .din   (r_tstate[1]),
    .dout  (w_buf_bit),
    .empty (w_buf_empty)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WRITE;
      r_cnt        <= '0;
      r_tstate     <= '0;
      r_out_bit    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        WRITE: begin
          if (in_valid) begin
            if (w_last) begin
              r_tstate <= best_state;
              r_cnt    <= '0;
              r_state  <= TRACE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_cnt != '0) begin
            // A gap breaks the shift alignment of the path memory: abort the frame.
            r_frame_err <= 1'b1;
            r_cnt       <= '0;
          end
        end
        TRACE: begin
          r_tstate <= prev_state(r_tstate, w_d);
`ifdef TB_REVERSE_EN
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= EMIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`else
          r_out_bit   <= r_tstate[1];
          r_out_valid <= 1'b1;
          if (w_last) begin
            r_frame_done <= 1'b1;
            r_cnt        <= '0;
            r_state      <= WRITE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        EMIT: begin
`ifdef TB_REVERSE_EN
          r_out_bit   <= w_buf_bit;
          r_out_valid <= !w_buf_empty;
          if (w_last) begin
            r_frame_done <= 1'b1;
            r_cnt        <= '0;
            r_state      <= WRITE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`else
          r_cnt   <= '0;
          r_state <= WRITE;
`endif
        end
        default: begin
          r_cnt   <= '0;
          r_state <= WRITE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb_ctrl.sv
// Directed self-checking bench for tb_ctrl; expectations adapt when TB_REVERSE_EN is defined.
module tb_tb_ctrl;
  import viterbi_pkg::*;

  localparam int D = 8;
`ifdef TB_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] best_state;
  logic       tbpm_we;
  logic [3:0] sel_i;
  logic       out_bit;
  logic       out_valid;
  logic       frame_done;
  logic       frame_err;

  int errors = 0;
  int checks = 0;

  tb_ctrl #(.TB_DEPTH(D), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .best_state (best_state),
    .tbpm_we    (tbpm_we),
    .sel_i      (sel_i),
    .out_bit    (out_bit),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive n consecutive valid cycles; in_valid is left high for the caller.
  task automatic write_frame(input logic [1:0] bs, input int n, output int we_cnt);
    we_cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid   = 1'b1;
      best_state = bs;
      #1;
      if (tbpm_we) we_cnt++;
    end
  endtask

  // Gather output bits until frame_done, maxbits, or a 64-cycle bound.
  task automatic collect(input int maxbits, output logic [31:0] bits, output int nbits,
                         output int fd_cnt, output int fd_idx, output int first_idx,
                         output int rdy_low, output int we_hi, output int err_cnt);
    bits = '0; nbits = 0; fd_cnt = 0; fd_idx = -1; first_idx = -1;
    rdy_low = 0; we_hi = 0; err_cnt = 0;
    for (int k = 0; k < 64 && nbits < maxbits && fd_cnt == 0; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (!in_ready) rdy_low++;
      if (tbpm_we)   we_hi++;
      if (frame_err) err_cnt++;
      if (out_valid) begin
        if (first_idx < 0) first_idx = k;
        bits[nbits] = out_bit;
        if (frame_done) fd_idx = nbits;
        nbits++;
      end
      if (frame_done) fd_cnt++;
    end
  endtask

  initial begin
    logic [31:0] bits;
    logic [31:0] bb_bits;
    int nbits, fd_cnt, fd_idx, first_idx, rdy_low, we_hi, err_cnt, we_cnt;
    int nb, fd, we, viol, e;

    rst_n = 1'b0; in_valid = 1'b0; best_state = 2'b00; sel_i = 4'b0000;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_tbpm_we",    tbpm_we,    0);
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_out_bit",    out_bit,    0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err",  frame_err,  0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic trace: best=11, all decisions 0
    sel_i = 4'b0000;
    write_frame(2'b11, D, we_cnt);
    chk("basic_we_cnt", we_cnt, D);
    collect(D, bits, nbits, fd_cnt, fd_idx, first_idx, rdy_low, we_hi, err_cnt);
    $display("basic: bits=%02h nbits=%0d fd_idx=%0d first=%0d", bits[7:0], nbits, fd_idx, first_idx);
    chk("basic_bits",    bits, REV ? 32'hC0 : 32'h03);
    chk("basic_nbits",   nbits, D);
    chk("basic_fd_cnt",  fd_cnt, 1);
    chk("basic_fd_idx",  fd_idx, D - 1);
    chk("basic_latency", first_idx, REV ? D + 1 : 1);
    chk("basic_we_post", we_hi, 0);
    chk("basic_rdy_low", rdy_low, REV ? 2 * D : D);

    // Opposite decisions: best=00, all decisions 1
    sel_i = 4'b1111;
    write_frame(2'b00, D, we_cnt);
    collect(D, bits, nbits, fd_cnt, fd_idx, first_idx, rdy_low, we_hi, err_cnt);
    $display("opposite: bits=%02h nbits=%0d rdy_low=%0d", bits[7:0], nbits, rdy_low);
    chk("opp_bits",    bits, REV ? 32'h3F : 32'hFC);
    chk("opp_rdy_low", rdy_low, REV ? 2 * D : D);
    chk("opp_fd_idx",  fd_idx, D - 1);

    // Gap after 5 writes
    sel_i = 4'b0010;
    write_frame(2'b01, 5, we_cnt);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("gap_no_err_yet", frame_err, 0);
    @(negedge clk);
    #1;
    $display("gap: frame_err=%0b in_ready=%0b", frame_err, in_ready);
    chk("gap_frame_err", frame_err, 1);
    chk("gap_in_ready",  in_ready, 1);
    @(negedge clk);
    #1;
    chk("gap_err_single", frame_err, 0);
    write_frame(2'b01, D, we_cnt);
    collect(D, bits, nbits, fd_cnt, fd_idx, first_idx, rdy_low, we_hi, err_cnt);
    $display("after gap: bits=%02h nbits=%0d errs=%0d", bits[7:0], nbits, err_cnt);
    chk("gap_bits",     bits, REV ? 32'h60 : 32'h06);
    chk("gap_fd_cnt",   fd_cnt, 1);
    chk("gap_no_2nd",   err_cnt, 0);

    // Reset after 3 output bits
    sel_i = 4'b0000;
    write_frame(2'b11, D, we_cnt);
    collect(3, bits, nbits, fd_cnt, fd_idx, first_idx, rdy_low, we_hi, err_cnt);
    chk("rstmid_part", bits, REV ? 32'h0 : 32'h3);
    rst_n = 1'b0;
    #1;
    $display("mid reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_in_ready",  in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid_quiet", out_valid, 0);
    write_frame(2'b11, D, we_cnt);
    collect(D, bits, nbits, fd_cnt, fd_idx, first_idx, rdy_low, we_hi, err_cnt);
    $display("after reset: bits=%02h nbits=%0d", bits[7:0], nbits);
    chk("rstmid_bits",  bits, REV ? 32'hC0 : 32'h03);
    chk("rstmid_nbits", nbits, D);

    // Back-to-back: in_valid held high across 3 frames
    sel_i = 4'b0101;
    bb_bits = '0; nb = 0; fd = 0; we = 0; viol = 0; e = 0;
    @(negedge clk);
    in_valid = 1'b1;
    best_state = 2'b10;
    #1;
    for (int k = 0; k < 200; k++) begin
      if (frame_err) e++;
      if (out_valid && nb < 32) begin
        bb_bits[nb] = out_bit;
        nb++;
      end
      if (frame_done) fd++;
      if (fd < 3 && tbpm_we) we++;
      if (tbpm_we && !in_ready) viol++;
      if (fd == 3) break;
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    in_valid = 1'b0;
    $display("b2b: bits=%06h nb=%0d fd=%0d we=%0d err=%0d", bb_bits[23:0], nb, fd, we, e);
    chk("b2b_nbits", nb, 3 * D);
    chk("b2b_bits",  bb_bits, REV ? 32'hAAAAAA : 32'h555555);
    chk("b2b_fd",    fd, 3);
    chk("b2b_we",    we, 3 * D);
    chk("b2b_err",   e, 0);
    chk("b2b_viol",  viol, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("end_idle_valid", out_valid, 0);
    chk("end_idle_err",   frame_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
